// File: rtl/bsg_link_ddr_deser_pkg.sv
// Shared types for the link DDR deserializer.
// The phase enum is exported so checkers can bind to the FSM state by name.
package bsg_link_ddr_deser_pkg;

  typedef enum logic {
    PHASE_LO = 1'b0,
    PHASE_HI = 1'b1
  } phase_e;

endpackage

// File: rtl/bsg_link_ddr_deser_two_fifo.sv
// Two-entry FIFO holding assembled link words.
// The caller may push while full only when it also pops in the same cycle.
module bsg_two_fifo #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem_r [2];
  logic               rd_ptr_r;
  logic               wr_ptr_r;
  logic [1:0]         count_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (v_i)    wr_ptr_r <= ~wr_ptr_r;
      if (yumi_i) rd_ptr_r <= ~rd_ptr_r;
      case ({v_i, yumi_i})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // When full, wr_ptr equals rd_ptr: the write lands in the slot being popped.
  always_ff @(posedge clk_i) begin
    if (v_i) mem_r[wr_ptr_r] <= data_i;
  end

  assign ready_o = (count_r != 2'd2);
  assign v_o     = (count_r != 2'd0);
  assign data_o  = mem_r[rd_ptr_r];

endmodule

// File: rtl/bsg_link_ddr_deser.sv
// Receive-side deserializer: pairs lo/hi link beats into full words and
// buffers two of them; drops and flags words that arrive with no room.
module bsg_link_ddr_deser
  import bsg_link_ddr_deser_pkg::*;
#(
  parameter int width_p = 128
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [width_p-1:0]   data_i,
  input  logic                 v_i,
  input  logic                 realign_i,
  output logic [2*width_p-1:0] data_o,
  output logic                 v_o,
  input  logic                 yumi_i,
  output logic                 overflow_o
);

  localparam int word_width_lp = 2 * width_p;

  logic [width_p-1:0]       data_r;
  logic [width_p-1:0]       lo_r;
  logic                     v_r;
  logic                     realign_r;
  logic                     overflow_r;
  phase_e                   phase_r;
  phase_e                   phase_n;
  logic                     lo_we;
  logic                     push;
  logic                     fifo_ready;
  logic                     fifo_v_in;
  logic                     drop;
  logic [word_width_lp-1:0] word;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_r       <= 1'b0;
      realign_r <= 1'b0;
    end else begin
      v_r       <= v_i;
      realign_r <= realign_i;
    end
  end

  always_ff @(posedge clk_i) begin
    data_r <= data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) phase_r <= PHASE_LO;
    else         phase_r <= phase_n;
  end

  // Realign wins over a valid beat in the same cycle and discards lo_r.
  always_comb begin
    phase_n = phase_r;
    lo_we   = 1'b0;
    push    = 1'b0;
    if (realign_r) begin
      phase_n = PHASE_LO;
    end else if (v_r) begin
      case (phase_r)
        PHASE_LO: begin
          lo_we   = 1'b1;
          phase_n = PHASE_HI;
        end
        PHASE_HI: begin
          push    = 1'b1;
          phase_n = PHASE_LO;
        end
        default: phase_n = PHASE_LO;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (lo_we) lo_r <= data_r;
  end

  assign word      = {data_r, lo_r};
  assign fifo_v_in = push & (fifo_ready | yumi_i);
  assign drop      = push & ~fifo_ready & ~yumi_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)   overflow_r <= 1'b0;
    else if (drop) overflow_r <= 1'b1;
  end

  // Output handshake: data_o is valid while v_o is high; yumi_i pulses
  // for one cycle to take the head word and may only be raised with v_o.
  bsg_two_fifo #(
    .width_p(word_width_lp)
  ) fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .ready_o(fifo_ready),
    .data_i (word),
    .v_i    (fifo_v_in),
    .v_o    (v_o),
    .data_o (data_o),
    .yumi_i (yumi_i)
  );

  assign overflow_o = overflow_r;

endmodule
